hazard_ctrl: RTL and testbench

- Central pipeline hazard controller for the five-stage MIPS core.
- Drives the operand-forwarding mux selects at the EX stage, and the stall, bubble and flush controls for the PC, IF/ID, ID/EX and EX/MEM registers.
- Sequences multi-cycle mult/div occupancy of EX with an internal FSM and counter.
- Keeps a saturating count of stall cycles for performance debug.

---
 rtl/hazard_ctrl_if.sv | 32 +++
 rtl/hazard_ctrl.sv | 117 +++++++++++
 tb/tb_hazard_ctrl.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-controller bundle: stage register fields in, stall/flush/forward controls out.
interface hazard_ctrl_if;
  logic [4:0] id_rs, id_rt;
  logic       id_muldiv;
  logic [4:0] ex_rs, ex_rt;
  logic       ex_mem_read;
  logic [4:0] ex_rd;
  logic       ex_branch_taken;
  logic       mem_reg_write;
  logic [4:0] mem_rd;
  logic       wb_reg_write;
  logic [4:0] wb_rd;

  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic       pc_stall, ifid_stall, idex_stall;
  logic       idex_bubble, exmem_bubble, ifid_flush;
  logic       md_busy, md_done;

  modport master (
    output id_rs, id_rt, id_muldiv, ex_rs, ex_rt, ex_mem_read, ex_rd,
           ex_branch_taken, mem_reg_write, mem_rd, wb_reg_write, wb_rd,
    input  fwd_a_sel, fwd_b_sel, pc_stall, ifid_stall, idex_stall,
           idex_bubble, exmem_bubble, ifid_flush, md_busy, md_done
  );

  modport slave (
    input  id_rs, id_rt, id_muldiv, ex_rs, ex_rt, ex_mem_read, ex_rd,
           ex_branch_taken, mem_reg_write, mem_rd, wb_reg_write, wb_rd,
    output fwd_a_sel, fwd_b_sel, pc_stall, ifid_stall, idex_stall,
           idex_bubble, exmem_bubble, ifid_flush, md_busy, md_done
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Five-stage MIPS hazard controller: EX operand forwarding, load-use stall,
// branch flush, mult/div EX occupancy FSM and a saturating stall-cycle counter.
module hazard_fwd_lane (
  input  logic [4:0] src,
  input  logic       mem_reg_write,
  input  logic [4:0] mem_rd,
  input  logic       wb_reg_write,
  input  logic [4:0] wb_rd,
  output logic [1:0] sel
);
  // EX/MEM holds the younger result, so it wins over MEM/WB.
  always_comb begin
    sel = 2'b00;
    if (mem_reg_write && mem_rd != 5'd0 && mem_rd == src)
      sel = 2'b10;
    else if (wb_reg_write && wb_rd != 5'd0 && wb_rd == src)
      sel = 2'b01;
  end
endmodule

module hazard_ctrl #(
  parameter int MULDIV_LAT = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  hazard_ctrl_if.slave     hz,
  output logic [CNT_W-1:0] stall_cnt
);
  localparam int NUM_OPS = 2;
  localparam logic [3:0] MD_LOAD = 4'(MULDIV_LAT - 2);

  typedef enum logic {IDLE, MD_BUSY} md_state_e;

  md_state_e        state;
  logic [3:0]       md_cnt;
  logic [CNT_W-1:0] cnt_q;

  logic [NUM_OPS-1:0][4:0] ex_src;
  logic [NUM_OPS-1:0][1:0] fwd_sel;
  logic lu, busy, md_start;
  logic pc_stall;

  assign ex_src = {hz.ex_rt, hz.ex_rs};

  for (genvar i = 0; i < NUM_OPS; i++) begin : g_fwd
    hazard_fwd_lane u_fwd (
      .src           (ex_src[i]),
      .mem_reg_write (hz.mem_reg_write),
      .mem_rd        (hz.mem_rd),
      .wb_reg_write  (hz.wb_reg_write),
      .wb_rd         (hz.wb_rd),
      .sel           (fwd_sel[i])
    );
  end

  assign lu = hz.ex_mem_read && hz.ex_rd != 5'd0 &&
              (hz.ex_rd == hz.id_rs || hz.ex_rd == hz.id_rt);
  assign busy = (state == MD_BUSY);
  // A taken branch discards the ID instruction, so it cannot start a mult/div.
  assign md_start = !rst && !busy && !hz.ex_branch_taken && !lu && hz.id_muldiv;

  always_comb begin
    hz.fwd_a_sel    = 2'b00;
    hz.fwd_b_sel    = 2'b00;
    pc_stall        = 1'b0;
    hz.ifid_stall   = 1'b0;
    hz.idex_stall   = 1'b0;
    hz.idex_bubble  = 1'b0;
    hz.exmem_bubble = 1'b0;
    hz.ifid_flush   = 1'b0;
    hz.md_busy      = 1'b0;
    hz.md_done      = 1'b0;
    if (!rst) begin
      hz.fwd_a_sel = fwd_sel[0];
      hz.fwd_b_sel = fwd_sel[1];
      if (busy) begin
        pc_stall        = 1'b1;
        hz.ifid_stall   = 1'b1;
        hz.idex_stall   = 1'b1;
        hz.exmem_bubble = 1'b1;
        hz.md_busy      = 1'b1;
        hz.md_done      = (md_cnt == 4'd0);
      end else if (hz.ex_branch_taken) begin
        hz.ifid_flush  = 1'b1;
        hz.idex_bubble = 1'b1;
      end else if (lu) begin
        pc_stall       = 1'b1;
        hz.ifid_stall  = 1'b1;
        hz.idex_bubble = 1'b1;
      end
    end
  end

  assign hz.pc_stall = pc_stall;
  assign stall_cnt   = rst ? '0 : cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      md_cnt <= 4'd0;
      cnt_q  <= '0;
    end else begin
      case (state)
        IDLE: if (md_start) begin
          state  <= MD_BUSY;
          md_cnt <= MD_LOAD;
        end
        MD_BUSY: if (md_cnt == 4'd0) state <= IDLE;
                 else                md_cnt <= md_cnt - 4'd1;
        default: state <= IDLE;
      endcase
      if (pc_stall && cnt_q != {CNT_W{1'b1}})
        cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl; expected responses are queued per cycle and checked by a monitor.
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_ctrl_if if1 ();
  hazard_ctrl_if if2 ();
  logic [15:0] stall_cnt;
  logic [1:0]  stall_cnt2;

  hazard_ctrl #(.MULDIV_LAT(4), .CNT_W(16)) dut  (.clk(clk), .rst(rst), .hz(if1.slave), .stall_cnt(stall_cnt));
  hazard_ctrl #(.MULDIV_LAT(4), .CNT_W(2))  dut2 (.clk(clk), .rst(rst), .hz(if2.slave), .stall_cnt(stall_cnt2));

  assign if2.id_rs = if1.id_rs;             assign if2.id_rt = if1.id_rt;
  assign if2.id_muldiv = if1.id_muldiv;     assign if2.ex_rs = if1.ex_rs;
  assign if2.ex_rt = if1.ex_rt;             assign if2.ex_mem_read = if1.ex_mem_read;
  assign if2.ex_rd = if1.ex_rd;             assign if2.ex_branch_taken = if1.ex_branch_taken;
  assign if2.mem_reg_write = if1.mem_reg_write; assign if2.mem_rd = if1.mem_rd;
  assign if2.wb_reg_write = if1.wb_reg_write;   assign if2.wb_rd = if1.wb_rd;

  typedef struct {
    logic rst; logic [4:0] id_rs, id_rt; logic id_muldiv;
    logic [4:0] ex_rs, ex_rt; logic ex_mem_read; logic [4:0] ex_rd; logic br;
    logic mem_rw; logic [4:0] mem_rd; logic wb_rw; logic [4:0] wb_rd;
  } stim_t;

  typedef struct {
    string nm; logic [1:0] fa, fb; logic [7:0] ctl; logic [15:0] sc; logic [1:0] sc2;
  } exp_t;

  // ctl = {pc_stall, ifid_stall, idex_stall, idex_bubble, exmem_bubble, ifid_flush, md_busy, md_done}
  localparam logic [7:0] NONE  = 8'b0000_0000;
  localparam logic [7:0] LU    = 8'b1101_0000;
  localparam logic [7:0] BUSY  = 8'b1110_1010;
  localparam logic [7:0] DONE  = 8'b1110_1011;
  localparam logic [7:0] FLUSH = 8'b0001_0100;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  function automatic stim_t z();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  function automatic stim_t lu_s(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    stim_t s;
    s = z();
    s.ex_mem_read = 1'b1; s.ex_rd = rd; s.id_rs = rs; s.id_rt = rt;
    return s;
  endfunction

  task automatic cyc(input stim_t s, input logic [1:0] fa, input logic [1:0] fb,
                     input logic [7:0] ctl, input int sc, input int sc2, input string nm);
    exp_t e;
    @(posedge clk); #1;
    rst = s.rst;
    if1.id_rs = s.id_rs; if1.id_rt = s.id_rt; if1.id_muldiv = s.id_muldiv;
    if1.ex_rs = s.ex_rs; if1.ex_rt = s.ex_rt; if1.ex_mem_read = s.ex_mem_read;
    if1.ex_rd = s.ex_rd; if1.ex_branch_taken = s.br;
    if1.mem_reg_write = s.mem_rw; if1.mem_rd = s.mem_rd;
    if1.wb_reg_write = s.wb_rw; if1.wb_rd = s.wb_rd;
    e.nm = nm; e.fa = fa; e.fb = fb; e.ctl = ctl; e.sc = 16'(sc); e.sc2 = 2'(sc2);
    sb.push_back(e);
  endtask

  exp_t        me;
  logic [7:0]  got_ctl;
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      me = sb.pop_front();
      got_ctl = {if1.pc_stall, if1.ifid_stall, if1.idex_stall, if1.idex_bubble,
                 if1.exmem_bubble, if1.ifid_flush, if1.md_busy, if1.md_done};
      checks++;
      if ({if1.fwd_a_sel, if1.fwd_b_sel} !== {me.fa, me.fb}) begin
        errors++;
        $display("FAIL %s fwd: got a=%b b=%b exp a=%b b=%b", me.nm, if1.fwd_a_sel, if1.fwd_b_sel, me.fa, me.fb);
      end
      checks++;
      if (got_ctl !== me.ctl) begin
        errors++;
        $display("FAIL %s ctl: got %b exp %b", me.nm, got_ctl, me.ctl);
      end
      checks++;
      if (stall_cnt !== me.sc) begin
        errors++;
        $display("FAIL %s stall_cnt: got %0d exp %0d", me.nm, stall_cnt, me.sc);
      end
      checks++;
      if (stall_cnt2 !== me.sc2) begin
        errors++;
        $display("FAIL %s stall_cnt_w2: got %0d exp %0d", me.nm, stall_cnt2, me.sc2);
      end
    end
  end

  initial begin
    stim_t s;
    rst = 1'b1;
    if1.id_rs = '0; if1.id_rt = '0; if1.id_muldiv = 1'b0; if1.ex_rs = '0; if1.ex_rt = '0;
    if1.ex_mem_read = 1'b0; if1.ex_rd = '0; if1.ex_branch_taken = 1'b0;
    if1.mem_reg_write = 1'b0; if1.mem_rd = '0; if1.wb_reg_write = 1'b0; if1.wb_rd = '0;

    // reset with hazards presented: everything still 0
    s = lu_s(5'd8, 5'd0, 5'd8); s.rst = 1'b1; s.mem_rw = 1'b1; s.mem_rd = 5'd5; s.ex_rs = 5'd5; s.br = 1'b1;
    cyc(s, 2'b00, 2'b00, NONE, 0, 0, "reset");
    s = z(); s.mem_rw = 1'b1; s.mem_rd = 5'd5; s.wb_rw = 1'b1; s.wb_rd = 5'd5; s.ex_rs = 5'd5;
    cyc(s, 2'b10, 2'b00, NONE, 0, 0, "fwd_mem_wins");
    s.mem_rw = 1'b0;
    cyc(s, 2'b01, 2'b00, NONE, 0, 0, "fwd_wb");
    s = z(); s.mem_rw = 1'b1; s.mem_rd = 5'd9; s.wb_rw = 1'b1; s.wb_rd = 5'd7; s.ex_rs = 5'd9; s.ex_rt = 5'd7;
    cyc(s, 2'b10, 2'b01, NONE, 0, 0, "fwd_split");
    s = z(); s.mem_rw = 1'b1; s.wb_rw = 1'b1;
    cyc(s, 2'b00, 2'b00, NONE, 0, 0, "fwd_r0");
    cyc(lu_s(5'd8, 5'd0, 5'd8), 2'b00, 2'b00, LU, 0, 0, "load_use");
    cyc(z(), 2'b00, 2'b00, NONE, 1, 1, "after_lu");
    cyc(lu_s(5'd0, 5'd0, 5'd8), 2'b00, 2'b00, NONE, 1, 1, "lu_r0");
    s = z(); s.id_muldiv = 1'b1;
    cyc(s, 2'b00, 2'b00, NONE, 1, 1, "md_issue");
    s = lu_s(5'd3, 5'd3, 5'd0); s.br = 1'b1;
    cyc(s, 2'b00, 2'b00, BUSY, 1, 1, "md_busy1");
    s = z(); s.mem_rw = 1'b1; s.mem_rd = 5'd4; s.ex_rs = 5'd4;
    cyc(s, 2'b10, 2'b00, BUSY, 2, 2, "md_busy2_fwd");
    cyc(z(), 2'b00, 2'b00, DONE, 3, 3, "md_done");
    cyc(z(), 2'b00, 2'b00, NONE, 4, 3, "md_idle");
    s = lu_s(5'd8, 5'd0, 5'd8); s.br = 1'b1; s.id_muldiv = 1'b1;
    cyc(s, 2'b00, 2'b00, FLUSH, 4, 3, "flush");
    cyc(z(), 2'b00, 2'b00, NONE, 4, 3, "after_flush");
    s = lu_s(5'd8, 5'd8, 5'd0); s.id_muldiv = 1'b1;
    cyc(s, 2'b00, 2'b00, LU, 4, 3, "lu_md");
    s = z(); s.id_muldiv = 1'b1;
    cyc(s, 2'b00, 2'b00, NONE, 5, 3, "md_issue2");
    cyc(s, 2'b00, 2'b00, BUSY, 5, 3, "md2_busy1");
    cyc(s, 2'b00, 2'b00, BUSY, 6, 3, "md2_busy2");
    cyc(s, 2'b00, 2'b00, DONE, 7, 3, "md2_done");
    cyc(s, 2'b00, 2'b00, NONE, 8, 3, "b2b_issue");
    cyc(z(), 2'b00, 2'b00, BUSY, 8, 3, "md3_busy1");
    s = z(); s.rst = 1'b1;
    cyc(s, 2'b00, 2'b00, NONE, 0, 0, "rst_mid_md");
    cyc(z(), 2'b00, 2'b00, NONE, 0, 0, "after_rst");
    for (int i = 0; i < 5; i++)
      cyc(lu_s(5'd2, 5'd2, 5'd0), 2'b00, 2'b00, LU, i, (i > 3) ? 3 : i, "sat_lu");
    cyc(z(), 2'b00, 2'b00, NONE, 5, 3, "sat_hold");

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expected responses never checked, exp 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
